// File: rtl/mem_req_arbiter.sv
// Arbitrates the core's single external memory port between icache, dcache and uncached requesters.
// One transaction at a time: address phase, then read beats steered or write beats sourced.
module mem_req_arbiter #(
   parameter int LINE_BEATS   = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic        dc_we,
   input  logic        uc_we,
   input  logic [31:0] ic_addr,
   input  logic [31:0] dc_addr,
   input  logic [31:0] uc_addr,
   input  logic [31:0] dc_wdata,
   input  logic [31:0] uc_wdata,
   input  logic [3:0]  uc_wstrb,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [2:0]  wready,
   output logic [2:0]  done,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [7:0]  mem_len,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rlast,
   output logic        mem_wvalid,
   output logic [31:0] mem_wdata,
   output logic        mem_wlast,
   input  logic        mem_wready,
   input  logic        mem_bvalid
);

   localparam logic [7:0] LINE_LEN   = 8'(LINE_BEATS - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      RDATA = 3'd2,
      WDATA = 3'd3,
      WRESP = 3'd4
   } state_t;

   state_t      state_r;
   logic [2:0]  owner_r;
   logic [7:0]  beat_cnt_r;
   logic [3:0]  starve_cnt_r;
   logic        busy_r;
   logic        mem_req_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [7:0]  mem_len_r;
   logic [3:0]  mem_wstrb_r;
   logic        mem_wvalid_r;
   logic [2:0]  sel_s;

   // Requester selection in IDLE: uc > dc > ic unless ic has been starved long enough.
   always_comb begin
      sel_s = 3'b000;
      if (req[0] && (starve_cnt_r >= STARVE_LIM)) begin
         sel_s = 3'b001;
      end else if (req[2]) begin
         sel_s = 3'b100;
      end else if (req[1]) begin
         sel_s = 3'b010;
      end else if (req[0]) begin
         sel_s = 3'b001;
      end else begin
         sel_s = 3'b000;
      end
   end

   // Transaction FSM with registered address-phase and write-valid outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         owner_r      <= 3'b000;
         beat_cnt_r   <= 8'd0;
         busy_r       <= 1'b0;
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= 32'd0;
         mem_len_r    <= 8'd0;
         mem_wstrb_r  <= 4'd0;
         mem_wvalid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (sel_s != 3'b000) begin
                  state_r    <= ADDR;
                  owner_r    <= sel_s;
                  busy_r     <= 1'b1;
                  mem_req_r  <= 1'b1;
                  beat_cnt_r <= 8'd0;
                  case (sel_s)
                     3'b100: begin
                        mem_we_r    <= uc_we;
                        mem_addr_r  <= uc_addr;
                        mem_len_r   <= 8'd0;
                        mem_wstrb_r <= uc_wstrb;
                     end
                     3'b010: begin
                        mem_we_r    <= dc_we;
                        mem_addr_r  <= dc_addr;
                        mem_len_r   <= LINE_LEN;
                        mem_wstrb_r <= 4'hF;
                     end
                     default: begin
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= ic_addr;
                        mem_len_r   <= LINE_LEN;
                        mem_wstrb_r <= 4'hF;
                     end
                  endcase
               end
            end
            ADDR: begin
               if (mem_gnt) begin
                  mem_req_r <= 1'b0;
                  if (mem_we_r) begin
                     state_r      <= WDATA;
                     mem_wvalid_r <= 1'b1;
                  end else begin
                     state_r <= RDATA;
                  end
               end
            end
            RDATA: begin
               if (mem_rvalid) begin
                  beat_cnt_r <= beat_cnt_r + 8'd1;
                  // rlast ends the burst regardless of how many beats were counted
                  if (mem_rlast) begin
                     state_r     <= IDLE;
                     owner_r     <= 3'b000;
                     busy_r      <= 1'b0;
                     beat_cnt_r  <= 8'd0;
                     mem_we_r    <= 1'b0;
                     mem_addr_r  <= 32'd0;
                     mem_len_r   <= 8'd0;
                     mem_wstrb_r <= 4'd0;
                  end
               end
            end
            WDATA: begin
               if (mem_wready) begin
                  beat_cnt_r <= beat_cnt_r + 8'd1;
                  if (beat_cnt_r == mem_len_r) begin
                     state_r      <= WRESP;
                     mem_wvalid_r <= 1'b0;
                  end
               end
            end
            WRESP: begin
               if (mem_bvalid) begin
                  state_r     <= IDLE;
                  owner_r     <= 3'b000;
                  busy_r      <= 1'b0;
                  beat_cnt_r  <= 8'd0;
                  mem_we_r    <= 1'b0;
                  mem_addr_r  <= 32'd0;
                  mem_len_r   <= 8'd0;
                  mem_wstrb_r <= 4'd0;
               end
            end
            default: begin
               state_r      <= IDLE;
               owner_r      <= 3'b000;
               busy_r       <= 1'b0;
               mem_req_r    <= 1'b0;
               mem_wvalid_r <= 1'b0;
            end
         endcase
      end
   end

   // Starvation counter: counts dc/uc wins while ic is waiting, saturating at 15.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (!req[0]) begin
         starve_cnt_r <= 4'd0;
      end else if (state_r == IDLE) begin
         if (sel_s[0]) begin
            starve_cnt_r <= 4'd0;
         end else if (starve_cnt_r != 4'd15) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Zero-latency steering of grant, read beats, write handshakes and completion to the owner.
   always_comb begin
      gnt       = 3'b000;
      rvalid    = 3'b000;
      wready    = 3'b000;
      done      = 3'b000;
      rdata     = 32'd0;
      mem_wdata = 32'd0;
      case (state_r)
         ADDR: begin
            if (mem_gnt) begin
               gnt = owner_r;
            end else begin
               gnt = 3'b000;
            end
         end
         RDATA: begin
            rdata = mem_rdata;
            if (mem_rvalid) begin
               rvalid = owner_r;
               if (mem_rlast) begin
                  done = owner_r;
               end else begin
                  done = 3'b000;
               end
            end else begin
               rvalid = 3'b000;
            end
         end
         WDATA: begin
            if (owner_r[1]) begin
               mem_wdata = dc_wdata;
            end else begin
               mem_wdata = uc_wdata;
            end
            if (mem_wready) begin
               wready = owner_r;
            end else begin
               wready = 3'b000;
            end
         end
         WRESP: begin
            if (mem_bvalid) begin
               done = owner_r;
            end else begin
               done = 3'b000;
            end
         end
         default: begin
            gnt = 3'b000;
         end
      endcase
   end

   assign busy       = busy_r;
   assign mem_req    = mem_req_r;
   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_len    = mem_len_r;
   assign mem_wstrb  = mem_wstrb_r;
   assign mem_wvalid = mem_wvalid_r;
   assign mem_wlast  = mem_wvalid_r && (beat_cnt_r == mem_len_r);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table of single transactions plus
// hand-written priority, starvation and mid-transaction reset sequences.
module tb_mem_req_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic        dc_we, uc_we;
   logic [31:0] ic_addr, dc_addr, uc_addr, dc_wdata, uc_wdata;
   logic [3:0]  uc_wstrb;
   logic [2:0]  gnt, rvalid, wready, done;
   logic [31:0] rdata;
   logic        busy, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_len;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid, mem_rlast, mem_wready, mem_bvalid;
   logic [31:0] mem_rdata;
   logic        mem_wvalid, mem_wlast;
   logic [31:0] mem_wdata;

   mem_req_arbiter #(.LINE_BEATS(8), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .req(req), .dc_we(dc_we), .uc_we(uc_we),
      .ic_addr(ic_addr), .dc_addr(dc_addr), .uc_addr(uc_addr),
      .dc_wdata(dc_wdata), .uc_wdata(uc_wdata), .uc_wstrb(uc_wstrb),
      .gnt(gnt), .rvalid(rvalid), .wready(wready), .done(done), .rdata(rdata),
      .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_len(mem_len), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
      .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
      .mem_wready(mem_wready), .mem_bvalid(mem_bvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          owner;
      logic        we;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  wstrb;
      logic [31:0] wbase;
   } exp_t;

   typedef struct {
      logic [2:0]  req;
      logic        dc_we;
      logic        uc_we;
      logic [31:0] uc_addr;
      logic [31:0] uc_wdata;
      logic [3:0]  uc_wstrb;
      bit          toggle;
      exp_t        exp;
   } vec_t;

   localparam logic [31:0] IC_A  = 32'h0000_1000;
   localparam logic [31:0] DC_A  = 32'h0000_2040;
   localparam logic [31:0] DC_WB = 32'hC0DE_0000;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [31:0] rpat(input logic [31:0] a, input int beat);
      return (a ^ 32'hA5A5_0000) + 32'(beat * 17);
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, " gnt"}, 32'(gnt), 32'd0);
      chk({tag, " rvalid"}, 32'(rvalid), 32'd0);
      chk({tag, " wready"}, 32'(wready), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " rdata"}, rdata, 32'd0);
      chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, " mem_addr"}, mem_addr, 32'd0);
      chk({tag, " mem_len"}, 32'(mem_len), 32'd0);
      chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
      chk({tag, " mem_wvalid"}, 32'(mem_wvalid), 32'd0);
      chk({tag, " mem_wlast"}, 32'(mem_wlast), 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
   endtask

   // Wait for the address phase, compare it with the scoreboard head, grant after two
   // cycles, then serve the data phase as the memory side and check steering.
   task automatic run_txn(input bit toggle);
      exp_t       e;
      logic [2:0] oh;
      int         waited = 0;
      int         beat = 0;
      int         cyc = 0;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      while (!mem_req && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!mem_req) begin
         chk("addr_phase_timeout", 32'(mem_req), 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_underflow", 32'(sb.size()), 32'd1);
         return;
      end
      e  = sb.pop_front();
      oh = 3'b001 << e.owner;
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_len", 32'(mem_len), 32'(e.len));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
      chk("busy_addr", 32'(busy), 32'd1);
      chk("gnt_early", 32'(gnt), 32'd0);
      @(negedge clk);
      #1;
      chk("addr_stable", mem_addr, e.addr);
      chk("mem_req_held", 32'(mem_req), 32'd1);
      @(negedge clk);
      mem_gnt = 1'b1;
      #1;
      chk("gnt", 32'(gnt), 32'(oh));
      if (!e.we) begin
         for (int b = 0; b <= int'(e.len); b++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            if (toggle && (b % 2 == 1)) begin
               mem_rvalid = 1'b0;
               mem_rlast  = 1'b0;
               #1;
               chk("rvalid_gap", 32'(rvalid), 32'd0);
               @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rpat(e.addr, b);
            mem_rlast  = (b == int'(e.len));
            #1;
            chk("rvalid", 32'(rvalid), 32'(oh));
            chk("rdata", rdata, rpat(e.addr, b));
            chk("done_rd", 32'(done), (b == int'(e.len)) ? 32'(oh) : 32'd0);
         end
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rlast  = 1'b0;
         #1;
         chk("busy_after_rd", 32'(busy), 32'd0);
      end else begin
         while (beat <= int'(e.len) && cyc < 64) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_wready = toggle ? (cyc % 2 == 1) : 1'b1;
            dc_wdata   = (e.owner == 1) ? e.wbase + 32'(beat) : 32'h0BAD_0BAD;
            #1;
            chk("mem_wvalid", 32'(mem_wvalid), 32'd1);
            chk("mem_wlast", 32'(mem_wlast), 32'(beat == int'(e.len)));
            if (mem_wready) begin
               chk("wready", 32'(wready), 32'(oh));
               chk("mem_wdata", mem_wdata, e.wbase + 32'(beat));
               beat++;
            end else begin
               chk("wready_idle", 32'(wready), 32'd0);
            end
            cyc++;
         end
         chk("wbeats", 32'(beat), 32'(e.len) + 32'd1);
         @(negedge clk);
         mem_wready = 1'b0;
         #1;
         chk("wvalid_wresp", 32'(mem_wvalid), 32'd0);
         chk("done_early", 32'(done), 32'd0);
         @(negedge clk);
         mem_bvalid = 1'b1;
         #1;
         chk("done_wr", 32'(done), 32'(oh));
         @(negedge clk);
         mem_bvalid = 1'b0;
         #1;
         chk("busy_after_wr", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{3'b001, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0, '{0, 1'b0, IC_A, 8'd7, 4'hF, 32'h0}};
      vecs[1] = '{3'b010, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b1, '{1, 1'b0, DC_A, 8'd7, 4'hF, 32'h0}};
      vecs[2] = '{3'b010, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b1, '{1, 1'b1, DC_A, 8'd7, 4'hF, DC_WB}};
      vecs[3] = '{3'b100, 1'b0, 1'b1, 32'h1FAF_0000, 32'hDEAD_BEEF, 4'b0011, 1'b0,
                  '{2, 1'b1, 32'h1FAF_0000, 8'd0, 4'b0011, 32'hDEAD_BEEF}};
      vecs[4] = '{3'b100, 1'b0, 1'b0, 32'h4000_0004, 32'h0, 4'b1100, 1'b0,
                  '{2, 1'b0, 32'h4000_0004, 8'd0, 4'b1100, 32'h0}};
      vecs[5] = '{3'b011, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0, '{1, 1'b1, DC_A, 8'd7, 4'hF, DC_WB}};
      vecs[6] = '{3'b110, 1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'hF, 1'b0,
                  '{2, 1'b0, 32'h4000_0008, 8'd0, 4'hF, 32'h0}};
      vecs[7] = '{3'b101, 1'b0, 1'b1, 32'h4000_000C, 32'h1234_5678, 4'hF, 1'b0,
                  '{2, 1'b1, 32'h4000_000C, 8'd0, 4'hF, 32'h1234_5678}};

      reset = 1'b1; req = 3'b000; dc_we = 1'b0; uc_we = 1'b0;
      ic_addr = IC_A; dc_addr = DC_A; uc_addr = 32'h0; dc_wdata = 32'h0; uc_wdata = 32'h0;
      uc_wstrb = 4'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_rlast = 1'b0;
      mem_wready = 1'b0; mem_bvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_idle("reset");
      reset = 1'b0;
      @(negedge clk);

      // Single transactions from the table
      for (int i = 0; i < 8; i++) begin
         dc_we = vecs[i].dc_we; uc_we = vecs[i].uc_we;
         uc_addr = vecs[i].uc_addr; uc_wdata = vecs[i].uc_wdata; uc_wstrb = vecs[i].uc_wstrb;
         sb.push_back(vecs[i].exp);
         req = vecs[i].req;
         run_txn(vecs[i].toggle);
         req = 3'b000;
      end

      // All three at once: uc, then dc, then ic
      dc_we = 1'b0; uc_we = 1'b1; uc_addr = 32'h5000_0010; uc_wdata = 32'hFACE_0001; uc_wstrb = 4'b1000;
      sb.push_back('{2, 1'b1, 32'h5000_0010, 8'd0, 4'b1000, 32'hFACE_0001});
      sb.push_back('{1, 1'b0, DC_A, 8'd7, 4'hF, 32'h0});
      sb.push_back('{0, 1'b0, IC_A, 8'd7, 4'hF, 32'h0});
      req = 3'b111;
      run_txn(1'b0);
      req[2] = 1'b0;
      run_txn(1'b0);
      req[1] = 1'b0;
      run_txn(1'b0);
      req = 3'b000;

      // ic waiting behind continuous dc traffic: four dc, then ic, then dc again
      dc_we = 1'b0;
      for (int i = 0; i < 4; i++) sb.push_back('{1, 1'b0, DC_A, 8'd7, 4'hF, 32'h0});
      sb.push_back('{0, 1'b0, IC_A, 8'd7, 4'hF, 32'h0});
      sb.push_back('{1, 1'b0, DC_A, 8'd7, 4'hF, 32'h0});
      req = 3'b011;
      for (int i = 0; i < 6; i++) run_txn(1'b0);
      req = 3'b000;

      // Reset during the fourth read beat, then a clean restart
      sb.push_back('{0, 1'b0, IC_A, 8'd7, 4'hF, 32'h0});
      req = 3'b001;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_seq mem_req", 32'(mem_req), 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
      mem_gnt = 1'b1;
      #1;
      chk("rst_seq gnt", 32'(gnt), 32'd1);
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rpat(IC_A, b); mem_rlast = 1'b0;
         #1;
         chk("rst_seq rvalid", 32'(rvalid), 32'd1);
      end
      @(negedge clk);
      reset = 1'b1; mem_rdata = rpat(IC_A, 3);
      @(negedge clk);
      reset = 1'b0; mem_rvalid = 1'b0;
      #1;
      chk_idle("mid_reset");
      sb.push_back('{0, 1'b0, IC_A, 8'd7, 4'hF, 32'h0});
      run_txn(1'b0);
      req = 3'b000;

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
